// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM states, register map and id width.
package int_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StService
    } state_e;

    localparam logic [1:0] RegMask = 2'd0;
    localparam logic [1:0] RegPend = 2'd1;
    localparam logic [1:0] RegMode = 2'd2;
    localparam logic [1:0] RegCur  = 2'd3;

    localparam int unsigned IdW = 3;

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Lowest-index-first priority encoder: source 0 always wins.
module prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int unsigned NSRC = 6
) (
    input  logic [NSRC-1:0] req_i,
    output logic            valid_o,
    output logic [IdW-1:0]  id_o
);

    always_comb begin
        valid_o = |req_i;
        id_o    = '0;
        // Walk downward so the lowest set index is the last assignment.
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o = IdW'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Programmable interrupt controller: per-source level/edge pending, mask, fixed priority,
// and a req/ack/EOI handshake toward the CPU.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned NSRC = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src_irq,
    input  logic [1:0]      Addr,
    input  logic            WE,
    input  logic [31:0]     Din,
    output logic [31:0]     Dout,
    output logic            cpu_irq,
    output logic [IdW-1:0]  cpu_irq_id,
    input  logic            cpu_ack
);

    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] hist_q;
    state_e          state_q, state_d;
    logic [IdW-1:0]  cur_id_q, cur_id_d;

    logic [NSRC-1:0] eligible, edge_set, w1c, ack_clr;
    logic [7:0]      elig8, cur_oh8;
    logic            win_valid;
    logic [IdW-1:0]  win_id;
    logic            wr_mask, wr_pend, wr_mode, wr_cur;
    logic            unused_din;

    assign unused_din = ^Din;

    assign wr_mask = WE && (Addr == RegMask);
    assign wr_pend = WE && (Addr == RegPend);
    assign wr_mode = WE && (Addr == RegMode);
    assign wr_cur  = WE && (Addr == RegCur);

    assign eligible = pend_q & mask_q;
    assign elig8    = 8'(eligible);
    assign cur_oh8  = 8'b1 << cur_id_q;

    prio_enc #(
        .NSRC (NSRC)
    ) u_prio_enc (
        .req_i   (eligible),
        .valid_o (win_valid),
        .id_o    (win_id)
    );

    always_comb begin
        mask_d   = wr_mask ? Din[NSRC-1:0] : mask_q;
        mode_d   = wr_mode ? Din[NSRC-1:0] : mode_q;
        edge_set = src_irq & ~hist_q;
        w1c      = wr_pend ? Din[NSRC-1:0] : '0;
        ack_clr  = (state_q == StReq && cpu_ack) ? cur_oh8[NSRC-1:0] : '0;
        // Edge bits: set beats clear. Level bits simply track the source.
        pend_d   = (mode_q & (edge_set | (pend_q & ~(w1c | ack_clr)))) | (~mode_q & src_irq);
    end

    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    cur_id_d = win_id;
                    state_d  = StReq;
                end
            end
            StReq: begin
                if (cpu_ack) begin
                    state_d = StService;
                end else if (!elig8[cur_id_q]) begin
                    state_d = StIdle;
                end
            end
            StService: begin
                if (wr_cur) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q   <= '0;
            mode_q   <= '0;
            pend_q   <= '0;
            hist_q   <= '0;
            state_q  <= StIdle;
            cur_id_q <= '0;
        end else begin
            mask_q   <= mask_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            hist_q   <= src_irq;
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
        end
    end

    assign cpu_irq    = (state_q == StReq);
    assign cpu_irq_id = cur_id_q;

    always_comb begin
        Dout = '0;
        unique case (Addr)
            RegMask: Dout = {{(32 - NSRC){1'b0}}, mask_q};
            RegPend: Dout = {{(32 - NSRC){1'b0}}, pend_q};
            RegMode: Dout = {{(32 - NSRC){1'b0}}, mode_q};
            RegCur:  Dout = {(state_q == StService), {(32 - 1 - IdW){1'b0}}, cur_id_q};
            default: Dout = '0;
        endcase
    end

endmodule
